rv64i_fetch_queue: RTL and testbench

// - Parametrised instruction prefetch queue between instruction memory and the IF/ID register of rv64i_pipeline.
// - Keeps up to DEPTH fetches in flight and hands {pc, instr} to decode in order over valid/ready.
// - Flushes on branch/jump redirect and discards stale memory responses.
// - Halt-aware: drains, then raises halted, the signal the pipeline bench uses to end simulation.

---
 rtl/rv64i_pkg.sv | 19 +
 rtl/rv64i_fq_storage.sv | 92 +++++++++
 rtl/rv64i_fetch_queue.sv | 103 ++++++++++
 tb/tb_rv64i_fetch_queue.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64i_pkg.sv
// Shared constants for the rv64i instruction-fetch front end.
//   XLEN      : PC / address width
//   ILEN      : instruction width
//   NOP_INSTR : canonical "addi x0,x0,0", shown on deq_instr when the head is empty
//   PC_STEP   : fetch stride in bytes
//   align_pc  : clears the two low PC bits (all fetches are word aligned)
package rv64i_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 64'd4;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv64i_fq_storage.sv
// Ring of DEPTH fetch entries {pc, instr, filled}.
//   clk, reset        : clock, asynchronous active-low reset
//   flush             : drop every entry and rewind all pointers
//   alloc_en/alloc_pc : reserve the tail entry for a newly accepted fetch
//   fill_en/fill_instr: write the oldest reserved-but-unfilled entry
//   pop_en            : retire the head entry
//   head_valid/pc/instr: head entry contents (head_valid = head has data)
//   count             : reserved entries (filled + awaiting data)
//   unfilled          : reserved entries still awaiting data
module rv64i_fq_storage
  import rv64i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       alloc_en,
  input  logic [XLEN-1:0]            alloc_pc,
  input  logic                       fill_en,
  input  logic [ILEN-1:0]            fill_instr,
  input  logic                       pop_en,
  output logic                       head_valid,
  output logic [XLEN-1:0]            head_pc,
  output logic [ILEN-1:0]            head_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] unfilled
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]   head_ptr_reg, tail_ptr_reg, fill_ptr_reg;
  logic [CW-1:0]   count_reg, unfilled_reg;
  logic [DEPTH-1:0] filled_reg, filled_next;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];

  // The three ports never target the same slot in one cycle in legal
  // operation (head is filled, fill slot is not, tail is free), so the
  // priority order below only matters for robustness.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flag
      assign filled_next[gi] =
        (pop_en   && head_ptr_reg == PW'(gi)) ? 1'b0 :
        (fill_en  && fill_ptr_reg == PW'(gi)) ? 1'b1 :
        (alloc_en && tail_ptr_reg == PW'(gi)) ? 1'b0 :
        filled_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      fill_ptr_reg <= '0;
      count_reg    <= '0;
      unfilled_reg <= '0;
      filled_reg   <= '0;
    end else if (flush) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      fill_ptr_reg <= '0;
      count_reg    <= '0;
      unfilled_reg <= '0;
      filled_reg   <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps the ring.
      if (alloc_en) tail_ptr_reg <= tail_ptr_reg + PW'(1);
      if (fill_en)  fill_ptr_reg <= fill_ptr_reg + PW'(1);
      if (pop_en)   head_ptr_reg <= head_ptr_reg + PW'(1);
      count_reg    <= count_reg    + CW'(alloc_en) - CW'(pop_en);
      unfilled_reg <= unfilled_reg + CW'(alloc_en) - CW'(fill_en);
      filled_reg   <= filled_next;
    end
  end

  // Payload needs no reset: the filled flags qualify everything read out.
  always_ff @(posedge clk) begin
    if (alloc_en) pc_mem[tail_ptr_reg]    <= alloc_pc;
    if (fill_en)  instr_mem[fill_ptr_reg] <= fill_instr;
  end

  assign head_valid = filled_reg[head_ptr_reg];
  assign head_pc    = pc_mem[head_ptr_reg];
  assign head_instr = head_valid ? instr_mem[head_ptr_reg] : NOP_INSTR;
  assign count      = count_reg;
  assign unfilled   = unfilled_reg;

endmodule

// File: rtl/rv64i_fetch_queue.sv
// Instruction prefetch queue between instruction memory and decode.
//   clk, reset               : clock, asynchronous active-low reset
//   redirect_valid/pc        : flush and restart fetch at redirect_pc (word aligned)
//   halt                     : stop fetching (sticky until reset)
//   imem_req_valid/ready/addr: fetch request channel
//   imem_rsp_valid/data      : in-order fetch responses
//   deq_valid/ready/pc/instr : in-order {pc, instr} hand-off to decode
//   count                    : reserved entries (filled + awaiting data)
//   halted                   : halt latched, queue empty, nothing outstanding
module rv64i_fetch_queue
  import rv64i_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       halt,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [ILEN-1:0]            imem_rsp_data,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [ILEN-1:0]            deq_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc_reg;
  logic [CW-1:0]   drop_cnt_reg;
  logic            halt_reg;

  logic [CW-1:0]   unfilled;
  logic [CW:0]     reserved;
  logic            req_fire, rsp_drop, fill_en, pop_en;

  // Slots already promised either to live entries or to responses that
  // will be thrown away after a redirect.
  assign reserved = {1'b0, count} + {1'b0, drop_cnt_reg};

  // Gating with reset keeps the request line low while reset is held.
  assign imem_req_valid = reset && !halt && !halt_reg && !redirect_valid &&
                          (reserved < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Stale responses are consumed first; a redirect discards even a
  // response that would otherwise have filled an entry.
  assign rsp_drop = imem_rsp_valid && (drop_cnt_reg != '0);
  assign fill_en  = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
  assign pop_en   = deq_valid && deq_ready && !redirect_valid;

  rv64i_fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .alloc_en   (req_fire),
    .alloc_pc   (fetch_pc_reg),
    .fill_en    (fill_en),
    .fill_instr (imem_rsp_data),
    .pop_en     (pop_en),
    .head_valid (deq_valid),
    .head_pc    (deq_pc),
    .head_instr (deq_instr),
    .count      (count),
    .unfilled   (unfilled)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= RESET_PC;
      drop_cnt_reg <= '0;
      halt_reg     <= 1'b0;
    end else begin
      if (halt) halt_reg <= 1'b1;
      if (redirect_valid) begin
        // Every fetch still in flight becomes stale; a response arriving
        // this very cycle is already one of them and is gone now.
        drop_cnt_reg <= drop_cnt_reg + unfilled - CW'(imem_rsp_valid);
        fetch_pc_reg <= align_pc(redirect_pc);
      end else begin
        if (rsp_drop) drop_cnt_reg <= drop_cnt_reg - CW'(1);
        if (req_fire) fetch_pc_reg <= fetch_pc_reg + PC_STEP;
      end
    end
  end

  assign halted = halt_reg && (count == '0) && (drop_cnt_reg == '0);

`ifndef SYNTHESIS
  // Memory may only answer requests it has accepted.
  rsp_has_owner: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (drop_cnt_reg != '0 || unfilled != '0));
`endif

endmodule

// File: tb/tb_rv64i_fetch_queue.sv
// Self-checking bench for rv64i_fetch_queue: directed scenarios plus
// randomized traffic, all compared every cycle against a queue-level model.
module tb_rv64i_fetch_queue;
  import rv64i_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [63:0] RST_PC = 64'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, redirect_valid, halt;
  logic [63:0]   redirect_pc;
  logic          imem_req_valid, imem_req_ready;
  logic [63:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          deq_valid, deq_ready;
  logic [63:0]   deq_pc;
  logic [31:0]   deq_instr;
  logic [CW-1:0] count;
  logic          halted;

  rv64i_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_instr(deq_instr), .count(count), .halted(halted)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // memory: fixed latency, strictly in order
  typedef struct { logic [63:0] addr; int due; } mreq_t;
  mreq_t memq[$];
  int    mem_lat = 1;
  int    cyc = 0;

  // reference model: ordered list of reserved fetches
  typedef struct { logic [63:0] pc; logic [31:0] instr; bit filled; } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc;
  int          m_drop;
  bit          m_halt;

  // DUT-side event logs for the directed scenarios
  logic [63:0] req_log[$];
  logic [63:0] pop_pc[$];
  logic [63:0] pop_instr[$];
  int first_req_cyc, first_deq_cyc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h13;
  endfunction

  function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    mq.delete();
    memq.delete();
    m_pc   = RST_PC;
    m_drop = 0;
    m_halt = 0;
  endtask

  // One clock cycle: inputs already applied at the negedge.
  task automatic cycle();
    bit e_req, e_deq, e_halted;
    int unf;
    imem_rsp_valid = (memq.size() > 0) && (memq[0].due == cyc);
    imem_rsp_data  = imem_rsp_valid ? mem_word(memq[0].addr) : 32'($urandom);
    #1;
    e_req    = reset && !halt && !m_halt && !redirect_valid && (mq.size() + m_drop < DEPTH);
    e_deq    = (mq.size() > 0) && mq[0].filled;
    e_halted = m_halt && (mq.size() == 0) && (m_drop == 0);
    chk("req_valid", 64'(imem_req_valid), 64'(e_req));
    chk("req_addr",  imem_req_addr, m_pc);
    chk("deq_valid", 64'(deq_valid), 64'(e_deq));
    if (e_deq) begin
      chk("deq_pc",    deq_pc, mq[0].pc);
      chk("deq_instr", 64'(deq_instr), 64'(mq[0].instr));
    end
    chk("count",  64'(count), 64'(mq.size()));
    chk("halted", 64'(halted), 64'(e_halted));

    // DUT-side observations
    if (reset && imem_req_valid && imem_req_ready) begin
      req_log.push_back(imem_req_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
      memq.push_back('{imem_req_addr, cyc + mem_lat});
    end
    if (reset && deq_valid && first_deq_cyc < 0) first_deq_cyc = cyc;
    if (reset && deq_valid && deq_ready && !redirect_valid) begin
      pop_pc.push_back(deq_pc);
      pop_instr.push_back(64'(deq_instr));
    end
    if (imem_rsp_valid) void'(memq.pop_front());

    // model next state
    if (reset) begin
      if (redirect_valid) begin
        unf = 0;
        foreach (mq[i]) if (!mq[i].filled) unf++;
        m_drop = m_drop + unf - (imem_rsp_valid ? 1 : 0);
        mq.delete();
        m_pc = {redirect_pc[63:2], 2'b00};
      end else begin
        if (imem_rsp_valid) begin
          if (m_drop > 0) m_drop--;
          else begin
            for (int i = 0; i < mq.size(); i++) begin
              if (!mq[i].filled) begin
                ent_t e;
                e = mq[i];
                e.filled = 1'b1;
                e.instr  = imem_rsp_data;
                mq[i] = e;
                break;
              end
            end
          end
        end
        if (e_deq && deq_ready) void'(mq.pop_front());
        if (e_req && imem_req_ready) begin
          mq.push_back('{m_pc, 32'h0, 1'b0});
          m_pc = m_pc + 64'd4;
        end
      end
      if (halt) m_halt = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    first_req_cyc = -1;
    first_deq_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    imem_req_ready = 1'b1;
    deq_ready = 1'b0;
    model_reset();
    cycle();
    cycle();
    reset = 1'b1;
    clear_logs();
  endtask

  int nreq, npop;

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    deq_ready = 1'b0;
    model_reset();
    clear_logs();
    @(negedge clk);

    // reset state
    do_reset();
    reset = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_count",     64'(count), 64'd0);
    chk("rst_halted",    64'(halted), 64'd0);
    chk("rst_addr",      imem_req_addr, RST_PC);

    // 1: streaming, latency 1
    do_reset();
    mem_lat = 1;
    deq_ready = 1'b1;
    repeat (8) cycle();
    chk("s1_req0", qat(req_log, 0), 64'h0);
    chk("s1_req1", qat(req_log, 1), 64'h4);
    chk("s1_req2", qat(req_log, 2), 64'h8);
    chk("s1_pop0", qat(pop_pc, 0), 64'h0);
    chk("s1_pop1", qat(pop_pc, 1), 64'h4);
    chk("s1_pop2", qat(pop_pc, 2), 64'h8);
    chk("s1_instr2", qat(pop_instr, 2), 64'(mem_word(64'h8)));
    chk("s1_latency", 64'(first_deq_cyc - first_req_cyc), 64'd2);

    // 2: consumer stalled, queue fills
    do_reset();
    deq_ready = 1'b0;
    repeat (8) cycle();
    chk("s2_nreq", 64'(req_log.size()), 64'd4);
    chk("s2_req3", qat(req_log, 3), 64'hC);
    chk("s2_count", 64'(count), 64'd4);
    chk("s2_req_blocked", 64'(imem_req_valid), 64'd0);
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
    cycle();
    chk("s2_req4", qat(req_log, 4), 64'h10);

    // 3: latency 3, redirect with two responses outstanding
    mem_lat = 3;
    do_reset();
    deq_ready = 1'b1;
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'h102;
    clear_logs();
    cycle();
    redirect_valid = 1'b0;
    repeat (12) cycle();
    chk("s3_req0", qat(req_log, 0), 64'h100);
    chk("s3_pop0", qat(pop_pc, 0), 64'h100);
    chk("s3_instr0", qat(pop_instr, 0), 64'(mem_word(64'h100)));

    // 4: redirect coincident with response and pop
    mem_lat = 1;
    do_reset();
    deq_ready = 1'b1;
    repeat (4) cycle();
    npop = pop_pc.size();
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    cycle();
    redirect_valid = 1'b0;
    chk("s4_no_pop", 64'(pop_pc.size()), 64'(npop));
    chk("s4_count0", 64'(count), 64'd0);
    pop_pc.delete();
    repeat (6) cycle();
    chk("s4_pop0", qat(pop_pc, 0), 64'h40);

    // 5: halt with three entries queued
    do_reset();
    deq_ready = 1'b0;
    repeat (3) cycle();
    chk("s5_count3", 64'(count), 64'd3);
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    nreq = req_log.size();
    deq_ready = 1'b1;
    repeat (6) cycle();
    chk("s5_halted", 64'(halted), 64'd1);
    chk("s5_no_req", 64'(req_log.size()), 64'(nreq));
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("s5_halted_after_redir", 64'(halted), 64'd1);
    chk("s5_req_low", 64'(imem_req_valid), 64'd0);

    // 6: reset mid-stream
    do_reset();
    deq_ready = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;
    #1;
    chk("s6_req_valid", 64'(imem_req_valid), 64'd0);
    chk("s6_deq_valid", 64'(deq_valid), 64'd0);
    chk("s6_count",     64'(count), 64'd0);
    chk("s6_halted",    64'(halted), 64'd0);
    model_reset();
    cycle();
    reset = 1'b1;
    clear_logs();
    cycle();
    chk("s6_first_req", qat(req_log, 0), RST_PC);

    // randomized traffic
    for (int ph = 0; ph < 4; ph++) begin
      mem_lat = 1 + (ph % 3);
      do_reset();
      for (int c = 0; c < 500; c++) begin
        imem_req_ready = ($urandom_range(99) < 75);
        deq_ready      = ($urandom_range(99) < 60);
        redirect_valid = ($urandom_range(99) < 4);
        redirect_pc    = ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF6
                                                  : {32'($urandom), 32'($urandom)};
        halt           = (ph == 3) && (c == 400);
        cycle();
      end
    end
    do_reset();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
